// File: rtl/text_terminal_writer_if.sv
// Byte-stream and video-RAM port bundle for text_terminal_writer.
// slave = the writer block, master = the byte source plus the video driver side.
interface text_terminal_writer_if;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic [5:0]  attr;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [15:0] mem_data;
  logic [15:0] mem_rdata;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;

  modport slave (
    input  char_valid, char_data, attr, mem_rdata,
    output char_ready, mem_we, mem_addr, mem_data, cursor_col, cursor_row
  );

  modport master (
    output char_valid, char_data, attr, mem_rdata,
    input  char_ready, mem_we, mem_addr, mem_data, cursor_col, cursor_row
  );
endinterface

// File: rtl/text_terminal_writer.sv
// Character-stream writer for the 40x30 text display: glyph/control decode, cursor upkeep,
// screen clear and bottom-row handling by read-modify-write. Scrolling enabled by TERM_SCROLL_EN.
module text_terminal_writer #(
  parameter int COLS       = 40,
  parameter int ROWS       = 30,
  parameter int CURSOR_BIT = 14
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  text_terminal_writer_if.slave bus
);
  localparam int          CELLS     = COLS * ROWS;
  localparam logic [10:0] LAST_CELL = 11'(CELLS - 1);
  localparam logic [10:0] COLS_W    = 11'(COLS);
  localparam logic [5:0]  LAST_COL  = 6'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);

  typedef enum logic [3:0] {
    INIT_CLR, IDLE, PUT, CLR_RD, CLR_WR, MOVE,
`ifdef TERM_SCROLL_EN
    SCR_RD, SCR_WR,
`endif
    SCR_CLR, SET_RD, SET_WR
  } state_t;

`ifdef TERM_SCROLL_EN
  // Bottom-row newline shifts every row up one, then blanks the last row.
  localparam state_t      ROWFIX_ST   = SCR_RD;
  localparam logic [10:0] ROWFIX_LAST = LAST_CELL;
  localparam logic [10:0] SHIFT_LAST  = 11'(CELLS - COLS - 1);
`else
  // Bottom-row newline wraps to row 0 and blanks that row.
  localparam state_t      ROWFIX_ST   = SCR_CLR;
  localparam logic [10:0] ROWFIX_LAST = 11'(COLS - 1);
`endif

  state_t      state_q, state_d;
  logic [5:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [10:0] base_q, base_d;
  logic [10:0] cnt_q, cnt_d;
  logic [7:0]  char_q, char_d;
  logic [5:0]  attr_q, attr_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic [10:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;

  logic        accept, printable, control;
  logic [10:0] cur_addr;
  logic        nl_edge;
  logic [4:0]  nl_row;
  logic [10:0] nl_base;
  logic [5:0]  bs_col;
  logic [4:0]  bs_row;
  logic [10:0] bs_base;

  function automatic logic [15:0] mark(input logic [15:0] w, input logic on);
    logic [15:0] r;
    r             = w;
    r[CURSOR_BIT] = on;
    return r;
  endfunction

  assign accept    = bus.char_valid & ready_q;
  assign printable = (bus.char_data >= 8'h20) && (bus.char_data <= 8'h7E);
  assign control   = bus.char_data inside {8'h08, 8'h0A, 8'h0C, 8'h0D};
  assign cur_addr  = base_q + {5'd0, col_q};

  always_comb begin
    nl_edge = (row_q == LAST_ROW);
    nl_row  = row_q + 5'd1;
    nl_base = base_q + COLS_W;
    if (nl_edge) begin
`ifdef TERM_SCROLL_EN
      nl_row  = row_q;
      nl_base = base_q;
`else
      nl_row  = 5'd0;
      nl_base = 11'd0;
`endif
    end
  end

  always_comb begin
    bs_col  = col_q;
    bs_row  = row_q;
    bs_base = base_q;
    if (col_q != 6'd0) begin
      bs_col = col_q - 6'd1;
    end else if (row_q != 5'd0) begin
      bs_col  = LAST_COL;
      bs_row  = row_q - 5'd1;
      bs_base = base_q - COLS_W;
    end
  end

  // Outputs registered here describe the action of state_q and appear one cycle later,
  // so a *_RD address is on the bus while the matching *_WR state samples mem_rdata.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    char_d  = char_q;
    attr_d  = attr_q;
    ready_d = 1'b0;
    we_d    = 1'b0;
    addr_d  = cur_addr;
    data_d  = 16'h0000;
    case (state_q)
      INIT_CLR: begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        cnt_d  = cnt_q + 11'd1;
        if (cnt_q == LAST_CELL) state_d = SET_RD;
      end
      IDLE: begin
        ready_d = ~accept;
        if (accept) begin
          char_d = bus.char_data;
          attr_d = bus.attr;
          if (printable)    state_d = PUT;
          else if (control) state_d = CLR_RD;
        end
      end
      PUT: begin
        we_d    = 1'b1;
        data_d  = {2'b00, attr_q, char_q};
        state_d = SET_RD;
        if (col_q == LAST_COL) begin
          col_d  = 6'd0;
          row_d  = nl_row;
          base_d = nl_base;
          if (nl_edge) begin
            state_d = ROWFIX_ST;
            cnt_d   = 11'd0;
          end
        end else begin
          col_d = col_q + 6'd1;
        end
      end
      CLR_RD: state_d = CLR_WR;
      CLR_WR: begin
        we_d    = 1'b1;
        data_d  = mark(bus.mem_rdata, 1'b0);
        state_d = MOVE;
      end
      MOVE: begin
        state_d = SET_RD;
        case (char_q)
          8'h0D: col_d = 6'd0;
          8'h0A: begin
            row_d  = nl_row;
            base_d = nl_base;
            if (nl_edge) begin
              state_d = ROWFIX_ST;
              cnt_d   = 11'd0;
            end
          end
          8'h08: begin
            col_d  = bs_col;
            row_d  = bs_row;
            base_d = bs_base;
            we_d   = 1'b1;
            addr_d = bs_base + {5'd0, bs_col};
            data_d = {2'b00, attr_q, 8'h00};
          end
          8'h0C: begin
            col_d   = 6'd0;
            row_d   = 5'd0;
            base_d  = 11'd0;
            cnt_d   = 11'd0;
            state_d = INIT_CLR;
          end
          default: ;
        endcase
      end
`ifdef TERM_SCROLL_EN
      SCR_RD: begin
        addr_d  = cnt_q + COLS_W;
        state_d = SCR_WR;
      end
      SCR_WR: begin
        we_d    = 1'b1;
        addr_d  = cnt_q;
        data_d  = bus.mem_rdata;
        cnt_d   = cnt_q + 11'd1;
        state_d = (cnt_q == SHIFT_LAST) ? SCR_CLR : SCR_RD;
      end
`endif
      SCR_CLR: begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        cnt_d  = cnt_q + 11'd1;
        if (cnt_q == ROWFIX_LAST) state_d = SET_RD;
      end
      SET_RD: state_d = SET_WR;
      SET_WR: begin
        we_d    = 1'b1;
        data_d  = mark(bus.mem_rdata, 1'b1);
        state_d = IDLE;
      end
      default: state_d = INIT_CLR;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= INIT_CLR;
      col_q   <= 6'd0;
      row_q   <= 5'd0;
      base_q  <= 11'd0;
      cnt_q   <= 11'd0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 11'd0;
      data_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    char_q <= char_d;
    attr_q <= attr_d;
  end

  assign bus.char_ready = ready_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_data   = data_q;
  assign bus.cursor_col = col_q;
  assign bus.cursor_row = row_q;
endmodule

// File: tb/tb_text_terminal_writer.sv
// Randomized bench for text_terminal_writer: video RAM model on the write port and a
// character-level screen model for expected contents, cursor and ready latency.
module tb_text_terminal_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   fill_en = 1'b0;
  always #5 clk = ~clk;

  text_terminal_writer_if bus();

  text_terminal_writer dut (
    .sys_clk (clk),
    .reset   (rst),
    .bus     (bus)
  );

`ifdef TERM_SCROLL_EN
  localparam int FIX_CYC = 2360;
`else
  localparam int FIX_CYC = 40;
`endif

  logic [15:0] ram [0:1199];
  int bad_addr = 0;
  int total = 0;
  int bad = 0;

  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < 1200; i++) ram[i] <= 16'($urandom);
    end else if (bus.mem_we) begin
      if (bus.mem_addr < 11'd1200) ram[bus.mem_addr] <= bus.mem_data;
      else bad_addr <= bad_addr + 1;
    end
  end

  always @(negedge clk)
    bus.mem_rdata <= (bus.mem_addr < 11'd1200) ? ram[bus.mem_addr] : 16'hDEAD;

  // Screen model: glyph words without the cursor mark, plus cursor position.
  logic [15:0] exp_scr [0:1199];
  int mcol, mrow;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic m_newline(output int extra);
    extra = 0;
    if (mrow < 29) begin
      mrow++;
    end else begin
      extra = FIX_CYC;
`ifdef TERM_SCROLL_EN
      for (int i = 0; i < 1160; i++) exp_scr[i] = exp_scr[i + 40];
      for (int i = 1160; i < 1200; i++) exp_scr[i] = 16'h0000;
`else
      mrow = 0;
      for (int i = 0; i < 40; i++) exp_scr[i] = 16'h0000;
`endif
    end
  endtask

  task automatic model_apply(input logic [7:0] b, input logic [5:0] a, output int lat);
    int extra;
    lat = 6;
    if (b >= 8'h20 && b <= 8'h7E) begin
      lat = 4;
      exp_scr[mrow * 40 + mcol] = {2'b00, a, b};
      if (mcol == 39) begin
        mcol = 0;
        m_newline(extra);
        lat += extra;
      end else begin
        mcol++;
      end
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h0A) begin
      m_newline(extra);
      lat += extra;
    end else if (b == 8'h08) begin
      if (mcol > 0) mcol--;
      else if (mrow > 0) begin
        mcol = 39;
        mrow--;
      end
      exp_scr[mrow * 40 + mcol] = {2'b00, a, 8'h00};
    end else if (b == 8'h0C) begin
      for (int i = 0; i < 1200; i++) exp_scr[i] = 16'h0000;
      mcol = 0;
      mrow = 0;
      lat  = 6 + 1200;
    end else begin
      lat = 1;
    end
  endtask

  task automatic cmp_screen(input string tag);
    int mism = 0;
    int first = -1;
    logic [15:0] e;
    for (int i = 0; i < 1200; i++) begin
      e = exp_scr[i];
      if (i == mrow * 40 + mcol) e[14] = 1'b1;
      if (ram[i] !== e) begin
        mism++;
        if (first < 0) first = i;
      end
    end
    chk($sformatf("%s_screen@%0d", tag, first), mism, 0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.char_ready !== 1'b1 && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Presents a byte and returns just after the accept edge; valid stays high with
  // junk data so any acceptance while not ready corrupts the screen.
  task automatic start_byte(input logic [7:0] b, input logic [5:0] a);
    int n;
    bus.char_valid = 1'b1;
    bus.char_data  = b;
    bus.attr       = a;
    wait_ready(n);
    if (bus.char_ready !== 1'b1) chk("ready_timeout", 32'(bus.char_ready), 1);
    @(posedge clk);
    #1;
    bus.char_data = 8'($urandom);
    bus.attr      = 6'($urandom);
  endtask

  task automatic send(input logic [7:0] b, input logic [5:0] a);
    int lat, n;
    start_byte(b, a);
    model_apply(b, a, lat);
    wait_ready(n);
    chk($sformatf("lat_%02h", b), n, lat);
    chk("col", 32'(bus.cursor_col), mcol);
    chk("row", 32'(bus.cursor_row), mrow);
    cmp_screen($sformatf("b%02h", b));
  endtask

  task automatic do_reset(input bit fill);
    int n;
    bus.char_valid = 1'b0;
    rst     = 1'b1;
    fill_en = fill;
    @(posedge clk);
    #1;
    fill_en = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.char_ready), 0);
    chk("rst_we",    32'(bus.mem_we), 0);
    chk("rst_addr",  32'(bus.mem_addr), 0);
    chk("rst_data",  32'(bus.mem_data), 0);
    chk("rst_col",   32'(bus.cursor_col), 0);
    chk("rst_row",   32'(bus.cursor_row), 0);
    rst = 1'b0;
    for (int i = 0; i < 1200; i++) exp_scr[i] = 16'h0000;
    mcol = 0;
    mrow = 0;
    wait_ready(n);
    chk("init_lat", n, 1203);
    cmp_screen("init");
  endtask

  function automatic logic [7:0] rnd_byte();
    int r = $urandom_range(0, 99);
    logic [7:0] v;
    if (r < 72)      v = 8'($urandom_range(32, 126));
    else if (r < 80) v = 8'h0A;
    else if (r < 86) v = 8'h0D;
    else if (r < 93) v = 8'h08;
    else if (r < 95) v = 8'h0C;
    else begin
      v = 8'($urandom_range(0, 255));
      if (v inside {[8'h20:8'h7E], 8'h08, 8'h0A, 8'h0C, 8'h0D}) v = 8'h7F;
    end
    return v;
  endfunction

  initial begin
    logic [5:0] a;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    bus.attr       = 6'h00;

    do_reset(1'b1);
    chk("cell0_init", 32'(ram[0]), 32'h4000);

    send(8'h41, 6'b001110);
    chk("cellA", 32'(ram[0]), 32'h0E41);
    chk("cell1_cursor", 32'(ram[1]), 32'h4000);

    for (int i = 0; i < 40; i++) send(8'($urandom_range(32, 126)), 6'($urandom));
    chk("line_col", 32'(bus.cursor_col), 1);
    chk("line_row", 32'(bus.cursor_row), 1);

    send(8'h08, 6'($urandom));
    a = 6'($urandom);
    send(8'h08, a);
    chk("bs_wrap_cell", 32'(ram[39]), 32'({2'b01, a, 8'h00}));
    chk("bs_wrap_col", 32'(bus.cursor_col), 39);
    send(8'h0D, 6'h00);
    send(8'h08, 6'h15);
    chk("bs_home_col", 32'(bus.cursor_col), 0);
    chk("bs_home_row", 32'(bus.cursor_row), 0);

    send(8'h0C, 6'h00);
    for (int i = 0; i < 29; i++) send(8'h0A, 6'h00);
    send(8'h5A, 6'h21);
    send(8'h0A, 6'h00);
`ifdef TERM_SCROLL_EN
    chk("scroll_z", 32'(ram[1120][7:0]), 32'h5A);
    chk("scroll_row", 32'(bus.cursor_row), 29);
`else
    chk("wrap_z", 32'(ram[1160][7:0]), 32'h5A);
    chk("wrap_row", 32'(bus.cursor_row), 0);
`endif

    for (int i = 0; i < 120; i++) send(rnd_byte(), 6'($urandom));

    send(8'h0C, 6'h3F);
    send(8'h41, 6'h01);

    start_byte(8'h0C, 6'h00);
    repeat ($urandom_range(3, 1100)) @(posedge clk);
    #1;
    do_reset(1'b0);

`ifdef TERM_SCROLL_EN
    for (int i = 0; i < 29; i++) send(8'h0A, 6'h00);
    send(8'h51, 6'h0A);
    start_byte(8'h0A, 6'h00);
    repeat ($urandom_range(100, 2300)) @(posedge clk);
    #1;
    do_reset(1'b0);
`endif

    send(8'h42, 6'h02);
    chk("bad_addr", bad_addr, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/text_terminal_writer.md
# text_terminal_writer

Character-stream front end for the 40x30 text display. Accepts one byte at a time from the USB keyboard/terminal logic and interprets it as a printable glyph or a control code. Owns the cursor position and drives the video-RAM write port (`we`, `mem_addr`, `mem_data`, `ret_data`) of the text video driver directly downstream. Performs screen clear, cursor maintenance and hardware scrolling by read-modify-write cycles on that port.

## Interface
- `COLS`, 40, text columns per row
- `ROWS`, 30, text rows
- `CURSOR_BIT`, 14, video-RAM word bit that marks the cursor cell

- `sys_clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `char_valid`  in  1  `char_data` holds a byte to consume
- `char_data`  in  8  ASCII byte
- `char_ready`  out  1  block can accept a byte this cycle
- `attr`  in  6  attribute for written glyphs, placed in word bits [13:8] (blink, inverted, RGB, intensity); sampled at accept
- `mem_we`  out  1  write strobe to video RAM
- `mem_addr`  out  11  cell address = row*COLS+col, 0..1199
- `mem_data`  out  16  write word
- `mem_rdata`  in  16  video RAM read data (`ret_data`)
- `cursor_col`  out  6  current column 0..39
- `cursor_row`  out  5  current row 0..29

## Operation
- Handshake: byte consumed on a rising edge with `char_valid & char_ready`. `char_ready`=1 only in IDLE. `char_data`/`attr` are registered at accept.
- States: INIT_CLR, IDLE, PUT, CLR_RD, CLR_WR, MOVE, SCR_RD, SCR_WR, SCR_CLR, SET_RD, SET_WR.
- Printable byte 0x20..0x7E: PUT writes `{1'b0, attr, char}` at cursor. This write also removes the cursor bit. Advance col; col 39 -> col 0, row+1 (newline rule). Then SET_RD/SET_WR.
- 0x0D CR: col=0.
- 0x0A LF: row+1.
- 0x08 BS: col>0 -> col-1. col=0,row>0 -> col 39, row-1. At (0,0): no move. In every case the destination cell is written `{1'b0, attr, 8'h00}`.
- 0x0C FF: clear all 1200 cells to 0x0000, home to (0,0).
- All other bytes are consumed and ignored (no RAM access).
- Control codes run CLR_RD -> CLR_WR (rewrite cursor cell with `CURSOR_BIT` cleared), then MOVE (update col/row), then SET_RD -> SET_WR.
- SET_RD/SET_WR: read the new cursor cell and write it back with `CURSOR_BIT` set.
- Newline at row 29: scroll (see Configuration). Row stays 29.
- Scroll: for i=0..1159, SCR_RD reads addr i+40 and SCR_WR writes that data to addr i. SCR_CLR then writes 0x0000 to 1160..1199.
- Row base is tracked incrementally (±40). No multiplier.
- Reset: col=row=0, enter INIT_CLR (clear 1200 cells, then SET at (0,0)).
- Reset values: `char_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0, `cursor_col`=0, `cursor_row`=0.

## Timing
- `mem_we`, `mem_addr`, `mem_data` are registered. Each state lasts one cycle.
- Read protocol: address is presented with `mem_we`=0 in an *_RD cycle. The driver latches `ret_data` on the falling edge. `mem_rdata` is sampled in the following *_WR cycle.
- Printable byte: accept edge -> PUT, SET_RD, SET_WR -> IDLE. `char_ready` high again 4 edges after accept.
- CR/LF/BS without scroll: CLR_RD, CLR_WR, MOVE, SET_RD, SET_WR. Ready 6 edges after accept.
- Scroll adds 2*1160+40 = 2360 cycles. FF and INIT_CLR take 1200 write cycles plus SET.
- Ignored byte: ready 1 edge after accept.
- `reset` asserted mid-sequence aborts it the same edge. Partial RAM contents are then overwritten by INIT_CLR.
- `cursor_col`/`cursor_row` change only on the MOVE/PUT edge.

## Configuration
- `TERM_SCROLL_EN` defined: a newline at row 29 scrolls as above.
- Undefined: scroll states are not compiled. A newline at row 29 wraps to row 0, and row 0 is cleared (40 write cycles) before SET.

## Test plan
- Reset held 2 cycles, then released -> 1200 writes of 0x0000, then cell 0 = 0x4000, `char_ready`=1, cursor (0,0).
- 'A' (0x41), attr=6'b001110 -> cell 0 = 0x0E41, cell 1 = 0x4000, cursor (1,0), ready 4 edges after accept.
- 41 printable bytes from home -> 41st lands at addr 40, cursor (1,1). `char_valid` held high is back-pressured by `char_ready`.
- BS at (0,1) after writing cell 39 -> cell 39 = {0,attr,00} with bit 14 set, cursor (39,0). BS at (0,0): no move.
- With `TERM_SCROLL_EN`: fill row 29 marker 'Z' at addr 1160, LF -> addr 1120 holds 'Z', 1160..1199 = 0 except cursor cell. Cursor row stays 29, ready after 2366 edges.
- FF mid-screen, and `reset` asserted during a scroll -> full clear, cursor (0,0), no write with addr ≥1200 ever issued.
